// File: rtl/mul_operand_issuer_pkg.sv
// Shared types and constants for the multiplier operand issuer.
// Operand a width is fixed; operand b width is a module parameter.
package mul_operand_issuer_pkg;

  localparam int unsigned OpaW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } issue_state_e;

  // Width of a 0..depth occupancy counter.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mul_operand_issuer_if.sv
// Producer-side valid/ready port and multiplier-side issue port of the operand issuer.
// The slave modport is the issuer's view; master is the producer/multiplier side.
interface mul_operand_issuer_if
  import mul_operand_issuer_pkg::*;
#(
  parameter int unsigned N = 4
) ();

  logic [OpaW-1:0] in_a;
  logic [N-1:0]    in_b;
  logic            in_vld;
  logic            in_rdy;
  logic [OpaW-1:0] mul_a;
  logic [N-1:0]    mul_b;
  logic            mul_vld;
  logic            mul_done;

  modport slave (
    input  in_a,
    input  in_b,
    input  in_vld,
    input  mul_done,
    output in_rdy,
    output mul_a,
    output mul_b,
    output mul_vld
  );

  modport master (
    output in_a,
    output in_b,
    output in_vld,
    output mul_done,
    input  in_rdy,
    input  mul_a,
    input  mul_b,
    input  mul_vld
  );

endinterface

// File: rtl/mul_operand_issuer_fifo.sv
// Synchronous FIFO with separate 0..Depth occupancy counter and wrapping pointers.
// Read data is the current head, valid whenever empty_o is low.
module mul_operand_issuer_fifo
  import mul_operand_issuer_pkg::*;
#(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = cnt_width(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  // Overflow/underflow requests are dropped rather than corrupting state.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mul_operand_issuer.sv
// Flow-controlled feeder for the shift multiplier: buffers operand pairs and issues one
// at a time, holding operands stable until the multiplier reports completion.
module mul_operand_issuer
  import mul_operand_issuer_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_operand_issuer_if.slave  io,
  output logic                 busy_o,
  output logic [CntW-1:0]      count_o,
  output logic                 err_o
);

  localparam int unsigned PairW = OpaW + N;

  issue_state_e    state_q, state_d;
  logic [OpaW-1:0] mul_a_q;
  logic [N-1:0]    mul_b_q;
  logic            err_q, err_d;
  logic            push, pop, full, empty;
  logic [PairW-1:0] head;

  // Ready depends on occupancy only; a pop at full frees a slot from the next cycle.
  assign io.in_rdy = !full;
  assign push      = io.in_vld && !full;

  mul_operand_issuer_fifo #(
    .Width (PairW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({io.in_a, io.in_b}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (io.mul_done) begin
          pop     = !empty;
          state_d = empty ? StIdle : StIssue;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A completion is only meaningful while an operation is outstanding.
  assign err_d = err_q || (io.mul_done && (state_q != StWait));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mul_a_q <= '0;
      mul_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (pop) begin
        {mul_a_q, mul_b_q} <= head;
      end
    end
  end

  assign io.mul_a   = mul_a_q;
  assign io.mul_b   = mul_b_q;
  assign io.mul_vld = (state_q == StIssue);
  assign busy_o     = (state_q != StIdle);
  assign err_o      = err_q;

endmodule
